// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port,
// with a pending-write scoreboard that raises decode RAW stalls.
module regfile_wb_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_hold,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  output logic               stall,
  output logic [31:0]        busy,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [1:0]         grant_id
);

  logic [1:0]    ptr;
  logic [1:0]    gnt_idx;
  logic [1:0]    cand;
  logic          found;
  logic          hs;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic [31:0]   busy_nxt;

  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    cand      = '0;
    found     = 1'b0;
    if (rst && !wb_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = 2'((int'(ptr) + k) % NREQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      if (found) req_ready[gnt_idx] = 1'b1;
    end
  end

  assign hs       = found;
  assign sel_rd   = req_rd[int'(gnt_idx)*AW +: AW];
  assign sel_data = req_data[int'(gnt_idx)*DW +: DW];

  // A new issue to the same rd outranks the retiring write
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      busy     <= '0;
    end else begin
      busy <= busy_nxt;
      if (hs) begin
        ptr      <= (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
        wr_en    <= (sel_rd != '0);
        wr_addr  <= sel_rd;
        wr_data  <= sel_data;
        grant_id <= gnt_idx;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  assign stall = (rs1 != '0 && busy[rs1]) || (rs2 != '0 && busy[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write stage,
// scoreboard and hold behaviour.
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [19:0]  req_rd;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wb_hold;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         stall;
  logic [31:0]  busy;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   grant_id;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wb_hold(wb_hold),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_rd[i*5 +: 5]    = 5'(i + 1);
      req_data[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    step();
    step();
    tests++;
    if (req_ready !== 4'b0000) begin
      $display("FAIL reset_ready got %b exp 0000", req_ready); fails++;
    end
    tests++;
    if (wr_en !== 1'b0 || busy !== 32'h0) begin
      $display("FAIL reset_state wr_en %b busy %h exp 0/0", wr_en, busy); fails++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL reset_first_grant got %b exp 0001", req_ready); fails++;
    end
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (req_ready !== 4'(1 << i)) begin
        $display("FAIL fair_ready%0d got %b exp %b", i, req_ready, 4'(1 << i)); fails++;
      end
      step();
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i + 1) ||
          wr_data !== 32'hA0 + 32'(i) || grant_id !== 2'(i)) begin
        $display("FAIL fair_write%0d got en%b a%0d d%h g%0d exp 1 %0d %h %0d",
                 i, wr_en, wr_addr, wr_data, grant_id, i + 1, 32'hA0 + i, i);
        fails++;
      end
    end
    req_valid = 4'b0000;
    step();
    tests++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd4 || wr_data !== 32'hA3) begin
      $display("FAIL fair_idle got en%b a%0d d%h exp 0 4 a3", wr_en, wr_addr, wr_data);
      fails++;
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    rs1 = 5'd5;
    #1;
    tests++;
    if (busy[5] !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL sb_set got busy5 %b stall %b exp 1 1", busy[5], stall); fails++;
    end
    req_valid = 4'b0010;
    req_rd[5 +: 5] = 5'd5;
    req_data[32 +: 32] = 32'h1234;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL sb_load_ready got %b exp 0010", req_ready); fails++;
    end
    step();
    req_valid = 4'b0000;
    #1;
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1234 ||
        grant_id !== 2'd1 || stall !== 1'b1) begin
      $display("FAIL sb_commit got en%b a%0d d%h g%0d stall%b exp 1 5 1234 1 1",
               wr_en, wr_addr, wr_data, grant_id, stall);
      fails++;
    end
    step();
    tests++;
    if (stall !== 1'b0 || busy[5] !== 1'b0 || wr_en !== 1'b0) begin
      $display("FAIL sb_clear got stall %b busy5 %b en %b exp 0 0 0", stall, busy[5], wr_en);
      fails++;
    end
    rs1 = 5'd0;
  endtask

  task automatic test_collision();
    req_valid = 4'b0001;
    req_rd[0 +: 5] = 5'd7;
    req_data[0 +: 32] = 32'h77;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL col_ready got %b exp 0001", req_ready); fails++;
    end
    step();
    req_valid = 4'b0000;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    rs2 = 5'd7;
    #1;
    tests++;
    if (busy[7] !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL col_set_wins got busy7 %b stall %b exp 1 1", busy[7], stall); fails++;
    end
    req_valid = 4'b1000;
    req_rd[15 +: 5] = 5'd7;
    req_data[96 +: 32] = 32'h700;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin
      $display("FAIL col_jump_ready got %b exp 1000", req_ready); fails++;
    end
    step();
    req_valid = 4'b0000;
    step();
    tests++;
    if (busy !== 32'h0 || stall !== 1'b0) begin
      $display("FAIL col_clear got busy %h stall %b exp 0 0", busy, stall); fails++;
    end
    rs2 = 5'd0;
  endtask

  task automatic test_x0();
    req_valid = 4'b0001;
    req_rd[0 +: 5] = 5'd0;
    req_data[0 +: 32] = 32'hFFFF;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL x0_ready got %b exp 0001", req_ready); fails++;
    end
    step();
    req_valid = 4'b0000;
    #1;
    tests++;
    if (wr_en !== 1'b0) begin
      $display("FAIL x0_no_write got %b exp 0", wr_en); fails++;
    end
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL x0_ptr_adv got %b exp 0010", req_ready); fails++;
    end
    req_valid = 4'b0000;
    issue_valid = 1'b1;
    issue_rd = 5'd0;
    step();
    issue_valid = 1'b0;
    #1;
    tests++;
    if (busy !== 32'h0 || stall !== 1'b0) begin
      $display("FAIL x0_busy got busy %h stall %b exp 0 0", busy, stall); fails++;
    end
  endtask

  task automatic test_hold();
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    req_valid = 4'b0010;
    req_rd[5 +: 5] = 5'd9;
    req_data[32 +: 32] = 32'h99;
    #1;
    tests++;
    if (req_ready !== 4'b0010 || busy[9] !== 1'b1) begin
      $display("FAIL hold_pre got ready %b busy9 %b exp 0010 1", req_ready, busy[9]); fails++;
    end
    step();
    wb_hold = 1'b1;
    req_valid = 4'b1111;
    #1;
    tests++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd9 || req_ready !== 4'b0000) begin
      $display("FAIL hold_commit got en%b a%0d ready %b exp 1 9 0000", wr_en, wr_addr, req_ready);
      fails++;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (req_ready !== 4'b0000 || wr_en !== 1'b0 || busy[9] !== 1'b0) begin
        $display("FAIL hold_block%0d got ready %b en %b busy9 %b exp 0000 0 0",
                 i, req_ready, wr_en, busy[9]);
        fails++;
      end
    end
    step();
    wb_hold = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL hold_release got %b exp 0100", req_ready); fails++;
    end
    step();
    req_valid = 4'b0000;
    tests++;
    if (wr_en !== 1'b1 || grant_id !== 2'd2) begin
      $display("FAIL hold_next got en%b g%0d exp 1 2", wr_en, grant_id); fails++;
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 4'b1000;
    req_rd[15 +: 5] = 5'd3;
    req_data[96 +: 32] = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (req_ready !== 4'b1000) begin
        $display("FAIL b2b_ready%0d got %b exp 1000", i, req_ready); fails++;
      end
      step();
      tests++;
      if (wr_en !== 1'b1 || grant_id !== 2'd3 || wr_data !== 32'hBEEF) begin
        $display("FAIL b2b_write%0d got en%b g%0d d%h exp 1 3 beef", i, wr_en, grant_id, wr_data);
        fails++;
      end
    end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    wb_hold = 1'b0;
    issue_valid = 1'b0;
    issue_rd = '0;
    rs1 = '0;
    rs2 = '0;
    step();
    test_reset();
    test_fairness();
    test_scoreboard();
    test_collision();
    test_x0();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters: ALU result, load data, LUI immediate and jump return address.
- Round-robin arbitration with valid/ready handshakes.
- Registered write-port outputs.
- 32-entry pending-write scoreboard that raises a read-after-write stall for the decode stage.
- Sits between the execute/memory stages and the register file write port.

Parameters:
NREQ, 4, number of writeback requesters; index 0=ALU, 1=load, 2=LUI, 3=jump
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  NREQ  per-requester write request
req_rd  in  NREQ*AW  packed destination register, requester i at [i*AW +: AW]
req_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
req_ready  out  NREQ  one-hot grant; handshake when valid&ready
wb_hold  in  1  freezes arbitration (no grants)
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination of issued instruction
rs1  in  AW  decode source 1
rs2  in  AW  decode source 2
stall  out  1  RAW hazard on rs1/rs2
busy  out  32  scoreboard bitmap
wr_en  out  1  register-file write enable
wr_addr  out  AW  register-file write address
wr_data  out  DW  register-file write data
grant_id  out  2  index of requester committed in current wr_* beat

Behaviour:
Reset (rst=0 at a rising edge):
- wr_en=0, wr_addr=0, wr_data=0, grant_id=0, busy=0, RR pointer=0.
- Any in-flight handshake is discarded.
- req_ready=0 while rst=0.

Arbitration (combinational):
- If wb_hold=1, req_ready=0.
- Otherwise, search req_valid starting at the RR pointer, ascending modulo NREQ.
- The first set bit gets req_ready=1; at most one bit is set. No valid request gives req_ready=0.
- The pointer updates only on a handshake, to (granted index + 1) mod NREQ.
- Requesters hold valid, rd and data stable until ready. Deasserting valid without a handshake is legal, and no write occurs.

Write stage:
- Latency is 1 cycle. A handshake in cycle N produces wr_en=1 in cycle N+1, with wr_addr=rd, wr_data=data and grant_id=index.
- No handshake in cycle N produces wr_en=0 in cycle N+1; wr_addr, wr_data and grant_id hold their last values.
- A handshake with rd=0 is accepted (ready asserted, pointer advances), but wr_en stays 0 in N+1, so x0 is never written.
- Sustained throughput is 1 write per cycle; there is no backpressure from the register file.

Scoreboard:
- busy[0] is hard-wired to 0.
- Set: at the edge where issue_valid=1 and issue_rd!=0, busy[issue_rd]<=1.
- Clear: at the edge ending any cycle with wr_en=1, busy[wr_addr]<=0.
- If set and clear target the same register on the same edge, set wins, because the newer issue is outstanding.
- stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]), combinational.
- There is no write-to-read bypass: stall is still 1 during the cycle wr_en=1 for that register, and drops the following cycle.

wb_hold:
- Blocks new grants only.
- A beat already registered still commits and clears busy.

Boundary conditions:
- All requesters valid: grants rotate 0,1,2,3,0 on consecutive cycles.
- A single requester valid every cycle is granted every cycle.
- Two requesters targeting the same rd commit in grant order; the last write wins in the register file.
- busy is cleared on the first commit to that rd.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, wr_en=0, busy=0. Release -> first grant is index 0.
- Fairness: req_valid=1111, rd=1..4, data=0xA0..0xA3 held for 4 cycles -> wr_en=1 for 4 consecutive cycles, starting one cycle after the first grant, with wr_addr 1,2,3,4, wr_data A0..A3 and grant_id 0,1,2,3.
- Scoreboard/stall: issue rd=5, then rs1=5 -> stall=1. Load writes rd=5 data=0x1234 -> stall=1 during the wr_en cycle and 0 the cycle after; busy[5]=0.
- Set/clear collision: wr_en commits rd=7 on the same edge issue_valid issues rd=7 -> busy[7] stays 1.
- x0 write: ALU requests rd=0 data=0xFFFF -> handshake occurs, wr_en stays 0. issue_rd=0 -> busy=0, stall=0 for rs1=0.
- wb_hold: granted beat in cycle N, wb_hold=1 in N+1..N+3 -> the N+1 write commits, no further req_ready, pointer unchanged. Release -> the next grant follows the unchanged pointer.
